// File: rtl/branch_predict_resolve.sv
// Branch predictor with a 2-bit saturating pattern table plus a resolve unit
// that evaluates branch conditions, trains the table and keeps statistics.
module branch_predict_resolve #(
   parameter int DATA_W = 16,
   parameter int IDX_W  = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              lk_valid,
   input  logic [DATA_W-1:0] lk_pc,
   output logic              pred_valid,
   output logic              pred_taken,
   input  logic              rv_valid,
   input  logic [DATA_W-1:0] rv_pc,
   input  logic [DATA_W-1:0] rv_rs,
   input  logic [4:0]        rv_op,
   input  logic              rv_pred,
   output logic              res_valid,
   output logic              res_taken,
   output logic              res_mispredict,
   output logic [CNT_W-1:0]  br_count,
   output logic [CNT_W-1:0]  mp_count,
   input  logic              clr_stats
);

   localparam int DEPTH = 2 ** IDX_W;

   // Handshake: lk_* and rv_* are single-cycle strobes with no backpressure;
   // each accepted request produces exactly one *_valid pulse one cycle later.

   logic [1:0]       pht [DEPTH];
   logic [IDX_W-1:0] lk_idx;
   logic [IDX_W-1:0] rv_idx;
   logic             is_cond;
   logic             is_jump;
   logic             cond_true;
   logic             act_taken;
   logic             act_mp;
   logic             counted;

   assign lk_idx = lk_pc[IDX_W:1];
   assign rv_idx = rv_pc[IDX_W:1];

   logic unused_pc_bits;
   assign unused_pc_bits = ^{lk_pc[DATA_W-1:IDX_W+1], lk_pc[0],
                             rv_pc[DATA_W-1:IDX_W+1], rv_pc[0]};

   always_comb begin
      is_cond   = (rv_op[4:2] == 3'b011);
      is_jump   = (rv_op[4:2] == 3'b001);
      cond_true = 1'b0;
      case (rv_op[1:0])
         2'b00:   cond_true = (rv_rs == '0);
         2'b01:   cond_true = (rv_rs != '0);
         2'b10:   cond_true = rv_rs[DATA_W-1];
         default: cond_true = ~rv_rs[DATA_W-1];
      endcase
      act_taken = is_jump | (is_cond & cond_true);
      counted   = rv_valid & (is_cond | is_jump);
      act_mp    = (is_cond | is_jump) & (act_taken != rv_pred);
   end

   // Pattern table; the lookup below reads the value before this edge's write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) pht[i] <= 2'b01;
      end else if (rv_valid && is_cond) begin
         if (act_taken) begin
            if (pht[rv_idx] != 2'b11) pht[rv_idx] <= pht[rv_idx] + 2'b01;
         end else begin
            if (pht[rv_idx] != 2'b00) pht[rv_idx] <= pht[rv_idx] - 2'b01;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pred_valid <= 1'b0;
         pred_taken <= 1'b0;
      end else begin
         pred_valid <= lk_valid;
         if (lk_valid) pred_taken <= pht[lk_idx][1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid      <= 1'b0;
         res_taken      <= 1'b0;
         res_mispredict <= 1'b0;
      end else begin
         res_valid <= rv_valid;
         if (rv_valid) begin
            res_taken      <= act_taken;
            res_mispredict <= act_mp;
         end
      end
   end

   // Statistics saturate at all-ones; a clear wins over a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_count <= '0;
         mp_count <= '0;
      end else if (clr_stats) begin
         br_count <= '0;
         mp_count <= '0;
      end else begin
         if (counted && !(&br_count)) br_count <= br_count + CNT_W'(1);
         if (counted && act_mp && !(&mp_count)) mp_count <= mp_count + CNT_W'(1);
      end
   end

endmodule
